div_ctrl: RTL and testbench



---
 rtl/div_ctrl_if.sv | 23 ++
 rtl/div_ctrl.sv | 128 ++++++++++++
 tb/tb_div_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Handshake bundle between the EX stage (master) and the iterative divider (slave).
interface div_ctrl_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic                 annul;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 stallreq;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  stallreq, ready, result
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output stallreq, ready, result
  );
endinterface

// File: rtl/div_ctrl.sv
// Iterative restoring divider for DIV/DIVU; result = {hi = remainder, lo = quotient}.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and returns 0.
module div_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  div_ctrl_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DZERO = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;

  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [WIDTH:0]     w_sh_rem;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH-1:0]   w_rem_next;
  logic [WIDTH-1:0]   w_quo_next;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [WIDTH-1:0]   w_quo_fix;

  // Signed operands are divided as magnitudes; signs are restored on the way out.
  assign w_mag1 = (bus.signed_div && bus.opdata1[WIDTH-1]) ? -bus.opdata1 : bus.opdata1;
  assign w_mag2 = (bus.signed_div && bus.opdata2[WIDTH-1]) ? -bus.opdata2 : bus.opdata2;

  // The shifted remainder keeps its carry-out bit so divisors >= 2^(WIDTH-1) still work.
  assign w_sh_rem   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_sh_rem - {1'b0, r_div};
  assign w_rem_next = w_diff[WIDTH] ? w_sh_rem[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_next = {r_quo[WIDTH-2:0], ~w_diff[WIDTH]};
  assign w_rem_fix  = r_neg_r ? -w_rem_next : w_rem_next;
  assign w_quo_fix  = r_neg_q ? -w_quo_next : w_quo_next;

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    bus.stallreq = 1'b0;
    bus.ready    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !rst) begin
          w_accept     = 1'b1;
          w_state_next = S_BUSY;
`ifdef DIV_ZERO_FAST_EN
          if (bus.opdata2 == '0) w_state_next = S_DZERO;
`endif
        end
      end
      S_BUSY: begin
        if (r_cnt == LAST) begin
          w_last       = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DZERO: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // A flush wins over everything except reset.
    if (bus.annul) begin
      w_state_next = S_IDLE;
      w_accept     = 1'b0;
      w_last       = 1'b0;
    end
    bus.stallreq = !rst && (w_accept || r_state == S_BUSY || r_state == S_DZERO);
    bus.ready    = (r_state == S_DONE) && !bus.annul;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else begin
      if (w_accept) begin
        r_cnt   <= '0;
        r_rem   <= '0;
        r_quo   <= w_mag1;
        r_div   <= w_mag2;
        r_neg_q <= bus.signed_div & (bus.opdata1[WIDTH-1] ^ bus.opdata2[WIDTH-1]);
        r_neg_r <= bus.signed_div & bus.opdata1[WIDTH-1];
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + CW'(1);
        r_rem <= w_rem_next;
        r_quo <= w_quo_next;
      end
      // The result register only changes on the way into DONE.
      if (w_last)
        r_result <= {w_rem_fix, w_quo_fix};
      else if (r_state == S_DZERO && !bus.annul)
        r_result <= '0;
    end
  end

  assign bus.result = r_result;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: vector table plus annul, reset and back-to-back sequences.
module tb_div_ctrl;
  localparam int W = 32;
`ifdef DIV_ZERO_FAST_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_ctrl_if #(.WIDTH(W)) bus();
  div_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t           vecs[13];
  logic [2*W-1:0] exp_q[$];
  int             n_tests = 0;
  int             n_fail  = 0;
  int             cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic do_div(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] exp, input int exp_lat, output int ready_cyc);
    int             lat;
    int             stalls;
    logic           got;
    logic [2*W-1:0] want;
    logic [2*W-1:0] res;
    @(negedge clk);
    check("ready_low_before_issue", 64'(bus.ready), 64'd0);
    bus.start      = 1'b1;
    bus.signed_div = sgn;
    bus.opdata1    = a;
    bus.opdata2    = b;
    exp_q.push_back(exp);
    #1;
    stalls = bus.stallreq ? 1 : 0;
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    got = 1'b0;
    res = '0;
    ready_cyc = cyc;
    while (!got && lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus.stallreq) stalls++;
      if (bus.ready) begin
        got       = 1'b1;
        ready_cyc = cyc;
        res       = bus.result;
        want      = exp_q.pop_front();
        check("result", res, want);
      end
    end
    if (!got) begin
      want = exp_q.pop_front();
      check("ready_seen", 64'(got), 64'd1);
    end else begin
      check("latency", 64'(lat), 64'(exp_lat));
      check("stall_cycles", 64'(stalls), 64'(exp_lat));
    end
    $display("[TB] div sgn=%0d a=%h b=%h result=%h lat=%0d stalls=%0d", sgn, a, b, res, lat, stalls);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2, pulses, stalls;
    rst = 1'b1;
    bus.start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
    bus.opdata1 = '0; bus.opdata2 = '0;

    vecs[0]  = '{1'b0, 32'd100,       32'd7,        64'h00000002_0000000E};
    vecs[1]  = '{1'b1, 32'hFFFFFF9C,  32'd7,        64'hFFFFFFFE_FFFFFFF2};
    vecs[2]  = '{1'b1, 32'h80000000,  32'hFFFFFFFF, 64'h00000000_80000000};
`ifdef DIV_ZERO_FAST_EN
    vecs[3]  = '{1'b0, 32'd5,         32'd0,        64'h00000000_00000000};
`else
    vecs[3]  = '{1'b0, 32'd5,         32'd0,        64'h00000005_FFFFFFFF};
`endif
    vecs[4]  = '{1'b0, 32'hFFFFFFFF,  32'd1,        64'h00000000_FFFFFFFF};
    vecs[5]  = '{1'b0, 32'hFFFFFFFF,  32'h80000000, 64'h7FFFFFFF_00000001};
    vecs[6]  = '{1'b1, 32'd100,       32'hFFFFFFF9, 64'h00000002_FFFFFFF2};
    vecs[7]  = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9, 64'hFFFFFFFE_0000000E};
    vecs[8]  = '{1'b0, 32'hFFFFFFFE,  32'hFFFFFFFF, 64'hFFFFFFFE_00000000};
    vecs[9]  = '{1'b0, 32'd3,         32'd5,        64'h00000003_00000000};
    vecs[10] = '{1'b1, 32'd7,         32'd2,        64'h00000001_00000003};
    vecs[11] = '{1'b0, 32'hFFFFFF9C,  32'd7,        64'h00000002_24924916};
    vecs[12] = '{1'b1, 32'd0,         32'd5,        64'h00000000_00000000};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_stallreq", 64'(bus.stallreq), 64'd0);
    check("reset_ready",    64'(bus.ready),    64'd0);
    check("reset_result",   bus.result,        64'd0);
    rst = 1'b0;

    for (int i = 0; i < 13; i++)
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp,
             (vecs[i].b == '0) ? ZLAT : 33, c1);

    // Back-to-back: second request issued in the IDLE cycle right after DONE
    do_div(1'b0, 32'd20, 32'd6, 64'h00000002_00000003, 33, c1);
    do_div(1'b0, 32'd1,  32'd1, 64'h00000000_00000001, 33, c2);
    check("b2b_ready_gap", 64'(c2 - c1), 64'd34);

    // Annul at BUSY iteration 10
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd1000; bus.opdata2 = 32'd3;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #1 bus.annul = 1'b1;
    @(posedge clk);
    #1 bus.annul = 1'b0;
    @(negedge clk);
    check("annul_stallreq", 64'(bus.stallreq), 64'd0);
    check("annul_ready",    64'(bus.ready),    64'd0);
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
    end
    check("annul_no_ready", 64'(pulses), 64'd0);
    check("annul_result_held", bus.result, 64'h00000000_00000001);
    $display("[TB] annul at iteration 10: ready pulses=%0d", pulses);
    do_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, c1);

    // Reset at BUSY iteration 5, start held high during reset
    @(negedge clk);
    bus.start = 1'b1; bus.signed_div = 1'b0; bus.opdata1 = 32'd100; bus.opdata2 = 32'd7;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 begin rst = 1'b1; bus.start = 1'b1; end
    @(negedge clk);
    @(negedge clk);
    check("rst_mid_ready",    64'(bus.ready),    64'd0);
    check("rst_mid_stallreq", 64'(bus.stallreq), 64'd0);
    check("rst_mid_result",   bus.result,        64'd0);
    @(negedge clk);
    check("rst_start_ignored_stall", 64'(bus.stallreq), 64'd0);
    rst = 1'b0; bus.start = 1'b0;
    pulses = 0; stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.ready) pulses++;
      if (bus.stallreq) stalls++;
    end
    check("rst_no_ready",   64'(pulses), 64'd0);
    check("rst_no_stall",   64'(stalls), 64'd0);
    $display("[TB] reset mid-busy: ready pulses=%0d stall cycles=%0d", pulses, stalls);
    do_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, c1);

    @(negedge clk);
    check("final_ready_low", 64'(bus.ready), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
